pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL support any value >= 1.
REQ-002 Parameter CW, default 16, width of the stall counter in bits; SHALL support any value >= 2.
REQ-003 Clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Rst  input  1  reset; asynchronous, active-high.
REQ-005 Flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-006 Clr  input  1  synchronous clear of Stall_Cnt only.
REQ-007 In_Valid  input  1  upstream has data on Din.
REQ-008 In_Ready  output  1  block can accept Din this cycle.
REQ-009 Din  input  DW  upstream data.
REQ-010 Out_Valid  output  1  Dout holds a valid entry.
REQ-011 Out_Ready  input  1  downstream accepts Dout this cycle.
REQ-012 Dout  output  DW  head entry; driven directly from the main register.
REQ-013 Occ  output  2  number of held entries (0, 1 or 2).
REQ-014 Stall_Cnt  output  CW  count of back-pressured cycles.

Function
REQ-015 The block SHALL hold up to two entries: a main register driving Dout and a skid register.
REQ-016 The state machine SHALL have three states: EMPTY (Occ=0), BUSY (Occ=1, main valid), FULL (Occ=2, main and skid valid).
REQ-017 Out_Valid SHALL equal 1 in BUSY and FULL, and 0 in EMPTY.
REQ-018 In_Ready SHALL be combinational: 1 in EMPTY or BUSY; 0 in FULL; 0 whenever Flush=1 or Rst=1.
REQ-019 Input transfer (acc_in) SHALL be In_Valid && In_Ready; output transfer (acc_out) SHALL be Out_Valid && Out_Ready.
REQ-020 EMPTY: on acc_in, main <= Din and go to BUSY; otherwise stay in EMPTY.
REQ-021 BUSY, acc_in && acc_out: main <= Din, stay in BUSY.
REQ-022 BUSY, acc_in && !acc_out: skid <= Din, go to FULL; main unchanged.
REQ-023 BUSY, !acc_in && acc_out: go to EMPTY.
REQ-024 BUSY, no transfer: hold.
REQ-025 FULL: on acc_out, main <= skid and go to BUSY; otherwise hold. No input is accepted in FULL.
REQ-026 Latency: data accepted into an EMPTY block SHALL appear on Dout with Out_Valid=1 in the next cycle; throughput SHALL be 1 entry/cycle while Out_Ready=1.
REQ-027 Ordering SHALL be strict FIFO; no entry is duplicated or dropped except by Flush or Rst.
REQ-028 Flush=1 SHALL force the next state to EMPTY regardless of other inputs; an acc_out in the same cycle still counts as delivered.
REQ-029 Data registers SHALL NOT be cleared by Flush; Dout is don't-care while Out_Valid=0.
REQ-030 Stall_Cnt SHALL increment by 1 in each cycle with Out_Valid=1 && Out_Ready=0, and SHALL saturate at 2^CW-1 (no wrap).
REQ-031 Clr=1 SHALL set Stall_Cnt to 0 next cycle, taking priority over increment; Flush SHALL NOT affect Stall_Cnt.
REQ-032 Occ SHALL be registered state-derived: EMPTY=0, BUSY=1, FULL=2; value 3 SHALL never occur.

Reset
REQ-033 Rst=1 SHALL immediately, without waiting for a clock edge, force: state EMPTY, Out_Valid=0, Occ=0, Stall_Cnt=0, main=0, skid=0, Dout=0.
REQ-034 While Rst=1, In_Ready SHALL be 0 and no transfer SHALL occur; Rst asserted mid-operation discards all held entries.
REQ-035 After Rst deasserts, the first rising edge SHALL behave as EMPTY with In_Ready=1.

Verification
REQ-036 Streaming: DW=32, Out_Ready=1, push 0x1..0x8 back-to-back -> Dout=0x1..0x8 on consecutive cycles, each 1 cycle after accept, In_Ready held at 1, Stall_Cnt=0.
REQ-037 Skid fill: push 0xA then 0xB with Out_Ready=0 -> Occ=2, In_Ready=0; Out_Ready=1 for 2 cycles -> Dout=0xA then 0xB, Occ 2->1->0.
REQ-038 Flush: FULL holding 0xA,0xB; Flush=1 with In_Valid=1, Din=0xC -> In_Ready=0 that cycle; next cycle Occ=0, Out_Valid=0; 0xC never appears.
REQ-039 Stall saturation: CW=2, Out_Valid=1, Out_Ready=0 for 6 cycles -> Stall_Cnt 1,2,3,3,3,3; Clr=1 with stall still active -> Stall_Cnt=0 next cycle.
REQ-040 Async reset: FULL state, assert Rst between clock edges -> Out_Valid=0, Occ=0, Dout=0 before the next edge; In_Ready=0 until Rst deasserts.
REQ-041 Random: random In_Valid/Out_Ready/Flush over 10k cycles against a scoreboard model -> no loss, duplication or reordering outside flushes; Occ always <= 2.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid slot: a main register drives dout,
// and a skid register absorbs one extra beat when downstream stalls.
module pipe_skid_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dout,
    output logic [1:0]    occ,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          acc_in;
    logic          acc_out;

    // in_ready stays combinational so a flush or reset blocks the beat in the same cycle
    assign in_ready  = !rst && !flush && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occ       = state;
    assign dout      = main_q;
    assign acc_in    = in_valid && in_ready;
    assign acc_out   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc_in) begin
                        main_q <= din;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (acc_in && acc_out) begin
                        main_q <= din;
                    end else if (acc_in) begin
                        skid_q <= din;
                        state  <= FULL;
                    end else if (acc_out) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (acc_out) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Back-pressure counter saturates at all-ones; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboard-driven checks for pipe_skid_reg (DW=32, CW=2).
module tb_pipe_skid_reg;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] din = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] dout;
    logic [1:0]    occ;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .occ       (occ),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change one time unit after a rising edge, then settle before checks
    task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy,
                                 input logic fl, input logic cl);
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        flush     = fl;
        clr       = cl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] q[$];
    logic          m_ready;
    logic          m_in;
    logic          m_out;
    int            m_stall;

    initial begin
        // Reset values while reset is held
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_occ", 32'(occ), 32'd0);
        checkOutput("rst_stall", 32'(stall_cnt), 32'd0);
        checkOutput("rst_dout", dout, 32'd0);
        applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("rst_no_xfer", 32'(out_valid), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
            checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            checkOutput("stream_valid", 32'(out_valid), 32'd1);
            checkOutput("stream_dout", dout, 32'(i));
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("stream_drained", 32'(occ), 32'd0);
        checkOutput("stream_stall", 32'(stall_cnt), 32'd0);

        // Skid fill then drain
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("skid_occ1", 32'(occ), 32'd1);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("skid_occ2", 32'(occ), 32'd2);
        checkOutput("skid_stall", 32'(stall_cnt), 32'd1);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        checkOutput("skid_in_ready", 32'(in_ready), 32'd0);
        checkOutput("skid_dout_a", dout, 32'hA);
        tick();
        checkOutput("skid_dout_b", dout, 32'hB);
        checkOutput("skid_occ_1", 32'(occ), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("skid_occ_0", 32'(occ), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("clr_stall", 32'(stall_cnt), 32'd0);

        // Flush while full with a competing input beat
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flush_pre_occ", 32'(occ), 32'd2);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("flush_occ", 32'(occ), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_stall_kept", 32'(stall_cnt), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("flush_no_c", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 32'hD, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("flush_next_d", dout, 32'hD);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("flush_clr", 32'(stall_cnt), 32'd0);

        // Stall counter saturation at 3, then clear during an active stall
        applyStimulus(1'b1, 32'hE, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            checkOutput("sat_stall", 32'(stall_cnt), (i < 3) ? 32'(i) : 32'd3);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("sat_clr", 32'(stall_cnt), 32'd0);

        // Asynchronous reset from FULL, between clock edges
        applyStimulus(1'b1, 32'hF, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("areset_pre_occ", 32'(occ), 32'd2);
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("areset_valid", 32'(out_valid), 32'd0);
        checkOutput("areset_occ", 32'(occ), 32'd0);
        checkOutput("areset_dout", dout, 32'd0);
        checkOutput("areset_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("areset_held", 32'(out_valid), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("areset_release", 32'(in_ready), 32'd1);

        // Randomised traffic against a queue scoreboard
        q.delete();
        m_stall = 0;
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 29) == 0), 1'b0);
            m_ready = !flush && (q.size() < 2);
            checkOutput("rnd_in_ready", 32'(in_ready), 32'(m_ready));
            m_in  = in_valid && m_ready;
            m_out = (q.size() > 0) && out_ready;
            if (m_out) checkOutput("rnd_dout", dout, q[0]);
            if ((q.size() > 0) && !out_ready && m_stall < 3) m_stall++;
            tick();
            if (m_out) void'(q.pop_front());
            if (flush) q.delete();
            else if (m_in) q.push_back(din);
            checkOutput("rnd_occ", 32'(occ), 32'(q.size()));
            checkOutput("rnd_stall", 32'(stall_cnt), 32'(m_stall));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
